// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: memory request/return, instruction stream to decode, branch redirect.
// master is the fetch controller side; slave is the memory/decode/branch environment.
interface fetch_ctrl_if #(
    parameter int WORD_SIZE  = 32,
    parameter int BLOCK_SIZE = 128
);
    logic [WORD_SIZE-1:0]  mem_addr;
    logic [BLOCK_SIZE-1:0] mem_rdata;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [WORD_SIZE-1:0]  inst;
    logic [WORD_SIZE-1:0]  inst_pc;
    logic                  redirect;
    logic [WORD_SIZE-1:0]  redirect_pc;

    modport master (
        output mem_addr,
        input  mem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_pc,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_pc,
        output redirect,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetches aligned blocks into a line buffer and streams words to decode; miss costs MEM_LATENCY+1 cycles.
// inst/inst_pc hold while inst_valid & !inst_ready; redirect flushes from any state, all outputs registered.
module fetch_ctrl #(
    parameter int                  WORD_SIZE   = 32,
    parameter int                  BYTE_SIZE   = 8,
    parameter int                  BLOCK_SIZE  = 128,
    parameter int                  MEM_LATENCY = 1,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);
    localparam int WPB = BLOCK_SIZE / WORD_SIZE;
    localparam int BPW = WORD_SIZE / BYTE_SIZE;
    localparam int WB  = $clog2(BPW);
    localparam int OB  = $clog2(WPB);
    localparam int BB  = WB + OB;
    localparam int CW  = $clog2(MEM_LATENCY + 1);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_SERVE
    } state_t;

    state_t                  state;
    logic [WORD_SIZE-1:0]    pc;
    logic [CW-1:0]           cnt;
    logic [BLOCK_SIZE-1:0]   line;
    logic [WORD_SIZE-1:BB]   line_tag;
    logic [WORD_SIZE-1:0]    mem_addr_q;
    logic                    inst_valid_q;
    logic [WORD_SIZE-1:0]    inst_q;
    logic [WORD_SIZE-1:0]    inst_pc_q;

    function automatic logic [WORD_SIZE-1:0] block_base(input logic [WORD_SIZE-1:0] a);
        return a & ~WORD_SIZE'(BLOCK_SIZE / BYTE_SIZE - 1);
    endfunction

    function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] a);
        return a & ~WORD_SIZE'(BPW - 1);
    endfunction

    // Word 0 sits in the most significant slot, so slot index is the bit-inverted offset.
    function automatic logic [WORD_SIZE-1:0] pick(input logic [BLOCK_SIZE-1:0] blk,
                                                  input logic [OB-1:0]         off);
        logic [WPB-1:0][WORD_SIZE-1:0] slots;
        slots = blk;
        return slots[~off];
    endfunction

    logic [OB-1:0]        cur_off;
    logic [OB-1:0]        nxt_off;
    logic [WORD_SIZE-1:0] nxt_in_line;
    logic [WORD_SIZE-1:0] pc_inc;

    assign cur_off     = pc[BB-1:WB];
    assign nxt_off     = cur_off + OB'(1);
    assign nxt_in_line = {line_tag, nxt_off, {WB{1'b0}}};
    assign pc_inc      = pc + WORD_SIZE'(BPW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= word_align(RESET_PC);
            cnt          <= '0;
            line         <= '0;
            line_tag     <= '0;
            mem_addr_q   <= block_base(RESET_PC);
            inst_valid_q <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
        end else if (bus.redirect) begin
            // A handshake in this same cycle still counts; the redirect target simply overrides pc.
            state        <= S_FETCH;
            pc           <= word_align(bus.redirect_pc);
            mem_addr_q   <= block_base(bus.redirect_pc);
            inst_valid_q <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    cnt   <= CW'(MEM_LATENCY);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        line         <= bus.mem_rdata;
                        line_tag     <= pc[WORD_SIZE-1:BB];
                        inst_q       <= pick(bus.mem_rdata, cur_off);
                        inst_pc_q    <= pc;
                        inst_valid_q <= 1'b1;
                        state        <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (bus.inst_ready) begin
                        if (cur_off == {OB{1'b1}}) begin
                            pc           <= pc_inc;
                            mem_addr_q   <= block_base(pc_inc);
                            inst_valid_q <= 1'b0;
                            state        <= S_FETCH;
                        end else begin
                            pc        <= nxt_in_line;
                            inst_pc_q <= nxt_in_line;
                            inst_q    <= pick(line, nxt_off);
                        end
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: latency-1 instance for the main scenarios, latency-3 instance for redirect during WAIT.
// Reference model tracks the expected program-counter stream and the valid gap after each restart.
module tb_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.WORD_SIZE(32), .BLOCK_SIZE(128)) bus1 ();
    fetch_ctrl_if #(.WORD_SIZE(32), .BLOCK_SIZE(128)) bus3 ();

    fetch_ctrl #(.MEM_LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fetch_ctrl #(.MEM_LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a < 32'd16) return 32'h11111111 * (32'(a[3:2]) + 32'd1);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5EED0000;
    endfunction

    function automatic logic [127:0] blk(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'hF;
        return {memword(b), memword(b + 32'd4), memword(b + 32'd8), memword(b + 32'd12)};
    endfunction

    // Registered-read memories of latency 1 and 3.
    logic [31:0] ap1;
    logic [31:0] ap3 [3];
    always_ff @(posedge clk) begin
        ap1    <= bus1.mem_addr;
        ap3[0] <= bus3.mem_addr;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
    end
    assign bus1.mem_rdata = blk(ap1);
    assign bus3.mem_rdata = blk(ap3[2]);

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_pc;
    int          since;
    int          cyc;
    logic        p_vld, p_rdy, p_redir;
    logic [31:0] p_inst, p_pc;
    logic        o_vld;
    logic [31:0] o_inst, o_pc, o_addr;

    // One cycle on instance 1: sample at negedge, check against the model, then drive inputs.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        cyc++;
        o_vld  = bus1.inst_valid;
        o_inst = bus1.inst;
        o_pc   = bus1.inst_pc;
        o_addr = bus1.mem_addr;
        checks++;
        if (o_vld !== (since >= 3)) begin
            failures++;
            $display("FAIL valid_timing cyc=%0d got=%b exp=%b", cyc, o_vld, since >= 3);
        end
        if (o_vld === 1'b1) begin
            checks++;
            if (o_pc !== exp_pc) begin
                failures++;
                $display("FAIL inst_pc cyc=%0d got=%h exp=%h", cyc, o_pc, exp_pc);
            end
            checks++;
            if (o_inst !== memword(exp_pc)) begin
                failures++;
                $display("FAIL inst_data cyc=%0d got=%h exp=%h", cyc, o_inst, memword(exp_pc));
            end
            if (p_vld && !p_rdy && !p_redir) begin
                checks++;
                if (o_inst !== p_inst || o_pc !== p_pc) begin
                    failures++;
                    $display("FAIL hold cyc=%0d got=%h/%h exp=%h/%h", cyc, o_inst, o_pc, p_inst, p_pc);
                end
            end
        end else begin
            checks++;
            if (o_addr !== (exp_pc & ~32'hF)) begin
                failures++;
                $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, o_addr, exp_pc & ~32'hF);
            end
        end
        bus1.inst_ready  = rdy;
        bus1.redirect    = redir;
        bus1.redirect_pc = rpc;
        if (redir) begin
            exp_pc = rpc & ~32'd3;
            since  = 1;
        end else if (o_vld === 1'b1 && rdy) begin
            since  = (exp_pc[3:2] == 2'd3) ? 1 : since + 1;
            exp_pc = exp_pc + 32'd4;
        end else begin
            since = (since < 1000) ? since + 1 : since;
        end
        p_vld = o_vld; p_rdy = rdy; p_redir = redir; p_inst = o_inst; p_pc = o_pc;
    endtask

    task automatic wait_valid;
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b0, 32'd0);
            n++;
        end while (o_vld !== 1'b1 && n < 20);
        checks++;
        if (o_vld !== 1'b1) begin
            failures++;
            $display("FAIL wait_valid timeout got=%b exp=1", o_vld);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus1.inst_valid !== 1'b0 || bus1.inst !== 32'd0 || bus1.inst_pc !== 32'd0 || bus1.mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_l1 got=%b/%h/%h/%h exp=0/0/0/0", bus1.inst_valid, bus1.inst, bus1.inst_pc, bus1.mem_addr);
        end
        checks++;
        if (bus3.inst_valid !== 1'b0 || bus3.inst !== 32'd0 || bus3.inst_pc !== 32'd0 || bus3.mem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_l3 got=%b/%h/%h/%h exp=0/0/0/0", bus3.inst_valid, bus3.inst, bus3.inst_pc, bus3.mem_addr);
        end
    endtask

    task automatic release_reset;
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = 32'd0;
        since  = 2;
        p_vld  = 1'b0;
    endtask

    task automatic test_first_block;
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (o_vld !== 1'b0) begin
            failures++;
            $display("FAIL first_wait got=%b exp=0", o_vld);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if (o_vld !== 1'b1 || o_pc !== 32'(i * 4) || o_inst !== 32'h11111111 * (i + 1)) begin
                failures++;
                $display("FAIL first_seq i=%0d got=%b/%h/%h exp=1/%h/%h", i, o_vld, o_pc, o_inst, i * 4, 32'h11111111 * (i + 1));
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if (o_vld !== 1'b0 || o_addr !== 32'd16) begin
                failures++;
                $display("FAIL first_gap i=%0d got=%b/%h exp=0/00000010", i, o_vld, o_addr);
            end
        end
    endtask

    task automatic test_backpressure;
        step(1'b0, 1'b1, 32'd0);
        wait_valid();
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0);
            checks++;
            if (o_vld !== 1'b1 || o_pc !== 32'd4 || o_inst !== 32'h22222222) begin
                failures++;
                $display("FAIL stall_hold i=%0d got=%b/%h/%h exp=1/4/22222222", i, o_vld, o_pc, o_inst);
            end
        end
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        checks++;
        if (o_pc !== 32'd8) begin
            failures++;
            $display("FAIL stall_advance got=%h exp=8", o_pc);
        end
    endtask

    task automatic test_redirect_serve;
        step(1'b0, 1'b1, 32'h26);
        step(1'b0, 1'b0, 32'd0);
        checks++;
        if (o_vld !== 1'b0 || o_addr !== 32'h20) begin
            failures++;
            $display("FAIL redir_fetch got=%b/%h exp=0/00000020", o_vld, o_addr);
        end
        step(1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'd0);
            checks++;
            if (o_vld !== 1'b1 || o_pc !== 32'h24 + 32'(i * 4)) begin
                failures++;
                $display("FAIL redir_seq i=%0d got=%b/%h exp=1/%h", i, o_vld, o_pc, 32'h24 + 32'(i * 4));
            end
        end
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (o_vld !== 1'b0 || o_addr !== 32'h30) begin
            failures++;
            $display("FAIL redir_next_fetch got=%b/%h exp=0/00000030", o_vld, o_addr);
        end
    endtask

    task automatic test_redirect_handshake;
        wait_valid();
        step(1'b1, 1'b1, 32'h100);
        wait_valid();
        checks++;
        if (o_pc !== 32'h100) begin
            failures++;
            $display("FAIL redir_hs got=%h exp=00000100", o_pc);
        end
    endtask

    task automatic test_wrap;
        step(1'b0, 1'b1, 32'hFFFFFFF9);
        wait_valid();
        checks++;
        if (o_pc !== 32'hFFFFFFF8) begin
            failures++;
            $display("FAIL wrap_align got=%h exp=fffffff8", o_pc);
        end
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (o_vld !== 1'b0 || o_addr !== 32'd0) begin
            failures++;
            $display("FAIL wrap_addr got=%b/%h exp=0/0", o_vld, o_addr);
        end
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (o_vld !== 1'b1 || o_pc !== 32'd0 || o_inst !== 32'h11111111) begin
            failures++;
            $display("FAIL wrap_first got=%b/%h/%h exp=1/0/11111111", o_vld, o_pc, o_inst);
        end
    endtask

    task automatic test_random;
        logic        rdy, redir;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            rdy   = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 31))) : $urandom;
            step(rdy, redir, redir ? rpc : 32'd0);
        end
    endtask

    task automatic test_reset_midwait;
        step(1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        release_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        checks++;
        if (o_vld !== 1'b1 || o_pc !== 32'd0 || o_inst !== 32'h11111111) begin
            failures++;
            $display("FAIL after_reset got=%b/%h/%h exp=1/0/11111111", o_vld, o_pc, o_inst);
        end
    endtask

    task automatic test_wait_redirect_l3;
        int  k;
        bit  seen_old;
        @(negedge clk);
        bus3.inst_ready  = 1'b0;
        bus3.redirect    = 1'b1;
        bus3.redirect_pc = 32'h40;
        @(negedge clk);
        bus3.redirect = 1'b0;
        checks++;
        if (bus3.inst_valid !== 1'b0 || bus3.mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL l3_fetch got=%b/%h exp=0/00000040", bus3.inst_valid, bus3.mem_addr);
        end
        @(negedge clk);
        bus3.redirect    = 1'b1;
        bus3.redirect_pc = 32'h86;
        @(negedge clk);
        bus3.redirect = 1'b0;
        checks++;
        if (bus3.inst_valid !== 1'b0 || bus3.mem_addr !== 32'h80) begin
            failures++;
            $display("FAIL l3_refetch got=%b/%h exp=0/00000080", bus3.inst_valid, bus3.mem_addr);
        end
        k = 0;
        seen_old = 0;
        while (bus3.inst_valid !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
            if (bus3.inst_valid === 1'b1 && bus3.inst_pc[31:4] == 28'h4) seen_old = 1;
        end
        checks++;
        if (k !== 4 || seen_old) begin
            failures++;
            $display("FAIL l3_latency got=%0d old=%0d exp=4 old=0", k, seen_old);
        end
        checks++;
        if (bus3.inst_pc !== 32'h84 || bus3.inst !== memword(32'h84)) begin
            failures++;
            $display("FAIL l3_data got=%h/%h exp=00000084/%h", bus3.inst_pc, bus3.inst, memword(32'h84));
        end
        bus3.inst_ready = 1'b1;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus3.inst_valid !== 1'b1 || bus3.inst_pc !== 32'h84 + 32'(i * 4) || bus3.inst !== memword(32'h84 + 32'(i * 4))) begin
                failures++;
                $display("FAIL l3_seq i=%0d got=%b/%h/%h exp=1/%h", i, bus3.inst_valid, bus3.inst_pc, bus3.inst, 32'h84 + 32'(i * 4));
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus3.inst_valid !== 1'b0 || bus3.mem_addr !== 32'h90) begin
                failures++;
                $display("FAIL l3_gap i=%0d got=%b/%h exp=0/00000090", i, bus3.inst_valid, bus3.mem_addr);
            end
        end
        @(negedge clk);
        checks++;
        if (bus3.inst_valid !== 1'b1 || bus3.inst_pc !== 32'h90) begin
            failures++;
            $display("FAIL l3_next got=%b/%h exp=1/00000090", bus3.inst_valid, bus3.inst_pc);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc = 0;
        exp_pc = 32'd0;
        since = 0;
        p_vld = 1'b0; p_rdy = 1'b0; p_redir = 1'b0; p_inst = 32'd0; p_pc = 32'd0;
        bus1.inst_ready = 1'b0; bus1.redirect = 1'b0; bus1.redirect_pc = 32'd0;
        bus3.inst_ready = 1'b0; bus3.redirect = 1'b0; bus3.redirect_pc = 32'd0;
        repeat (3) @(negedge clk);
        test_reset();
        release_reset();
        test_first_block();
        test_backpressure();
        test_redirect_serve();
        test_redirect_handshake();
        test_wrap();
        test_random();
        test_reset_midwait();
        test_wait_redirect_l3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
